// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//
// Single-clock parametrised FIFO. All DEPTH entries are usable. The block
// provides an occupancy count, almost-full/almost-empty thresholds, a
// read-data-valid strobe, a synchronous flush and sticky error flags.
//
// Ports
//   CLK    in   1        clock, all state changes on the rising edge
//   RSTN   in   1        asynchronous active-low reset
//   DIN    in   WIDTH    write data
//   WE     in   1        write request
//   RREQ   in   1        read request
//   FLUSH  in   1        synchronous clear of contents and error flags
//   DO     out  WIDTH    registered read data
//   DV     out  1        DO was updated by a read accepted on the last edge
//   FF     out  1        full  (CNT == DEPTH)
//   FE     out  1        empty (CNT == 0)
//   AF     out  1        almost full  (CNT >= AF_LVL)
//   AE     out  1        almost empty (CNT <= AE_LVL)
//   CNT    out  AW+1     current occupancy, 0..DEPTH
//   OVF    out  1        sticky: a write was rejected
//   UNF    out  1        sticky: a read was rejected
// ---------------------------------------------------------------------------
module sync_fifo_param #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned AF_LVL = DEPTH - 2,
   parameter int unsigned AE_LVL = 2
) (
   input  logic                      CLK,
   input  logic                      RSTN,
   input  logic [WIDTH-1:0]          DIN,
   input  logic                      WE,
   input  logic                      RREQ,
   input  logic                      FLUSH,
   output logic [WIDTH-1:0]          DO,
   output logic                      DV,
   output logic                      FF,
   output logic                      FE,
   output logic                      AF,
   output logic                      AE,
   output logic [$clog2(DEPTH):0]    CNT,
   output logic                      OVF,
   output logic                      UNF
);

   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic [AW-1:0] PTR_INC  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_INC  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   AF_THR   = (AW+1)'(AF_LVL);
   localparam logic [AW:0]   AE_THR   = (AW+1)'(AE_LVL);

   // Storage is deliberately not reset.
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]    rp_q,  rp_d;
   logic [AW-1:0]    wp_q,  wp_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0] do_q,  do_d;
   logic             dv_q,  dv_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             full_s;
   logic             empty_s;
   logic             rd_ok_s;
   logic             wr_ok_s;

   // Status decode depends on the registered count only.
   always_comb begin
      full_s  = (cnt_q == CNT_FULL);
      empty_s = (cnt_q == {(AW+1){1'b0}});
   end

   // Accept decisions; a full FIFO still takes a write when a read frees a slot
   // on the same edge, but an empty FIFO never bypasses DIN to DO.
   always_comb begin
      rd_ok_s = 1'b0;
      wr_ok_s = 1'b0;
      if (!FLUSH) begin
         rd_ok_s = RREQ && !empty_s;
         wr_ok_s = WE && (!full_s || rd_ok_s);
      end else begin
         rd_ok_s = 1'b0;
         wr_ok_s = 1'b0;
      end
   end

   // Next-state computation for pointers, count, read data and error flags.
   always_comb begin
      rp_d  = rp_q;
      wp_d  = wp_q;
      cnt_d = cnt_q;
      do_d  = do_q;
      dv_d  = 1'b0;
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (FLUSH) begin
         // Flush wins over requests; DO keeps its last value.
         rp_d  = {AW{1'b0}};
         wp_d  = {AW{1'b0}};
         cnt_d = {(AW+1){1'b0}};
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end else begin
         if (rd_ok_s) begin
            do_d = mem_q[rp_q];
            dv_d = 1'b1;
            rp_d = rp_q + PTR_INC;
         end else begin
            do_d = do_q;
         end
         if (wr_ok_s) begin
            wp_d = wp_q + PTR_INC;
         end else begin
            wp_d = wp_q;
         end
         case ({wr_ok_s, rd_ok_s})
            2'b10:   cnt_d = cnt_q + CNT_INC;
            2'b01:   cnt_d = cnt_q - CNT_INC;
            default: cnt_d = cnt_q;
         endcase
         if (WE && !wr_ok_s) begin
            ovf_d = 1'b1;
         end else begin
            ovf_d = ovf_q;
         end
         if (RREQ && !rd_ok_s) begin
            unf_d = 1'b1;
         end else begin
            unf_d = unf_q;
         end
      end
   end

   // Control and output registers with asynchronous reset.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rp_q  <= {AW{1'b0}};
         wp_q  <= {AW{1'b0}};
         cnt_q <= {(AW+1){1'b0}};
         do_q  <= {WIDTH{1'b0}};
         dv_q  <= 1'b0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         rp_q  <= rp_d;
         wp_q  <= wp_d;
         cnt_q <= cnt_d;
         do_q  <= do_d;
         dv_q  <= dv_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Storage array write port.
   always_ff @(posedge CLK) begin
      if (wr_ok_s) begin
         mem_q[wp_q] <= DIN;
      end
   end

   assign DO  = do_q;
   assign DV  = dv_q;
   assign CNT = cnt_q;
   assign OVF = ovf_q;
   assign UNF = unf_q;
   assign FF  = full_s;
   assign FE  = empty_s;
   assign AF  = (cnt_q >= AF_THR);
   assign AE  = (cnt_q <= AE_THR);

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
//
// Directed bench for sync_fifo_param. Three instances: DEPTH=8 driven from a
// vector table and a flush sequence, DEPTH=16 for an async reset mid-stream,
// DEPTH=4 for pointer wrap-around.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

   typedef struct packed {
      logic       we;
      logic       rreq;
      logic       flush;
      logic [7:0] din;
      logic [7:0] e_do;
      logic       e_dv;
      logic [3:0] e_cnt;
      logic       e_ff;
      logic       e_fe;
      logic       e_af;
      logic       e_ae;
      logic       e_ovf;
      logic       e_unf;
   } vec_t;

   logic clk;
   logic rst_n;
   logic rst16_n;

   // DEPTH=8 instance signals
   logic [7:0] din8;
   logic       we8, rreq8, flush8;
   logic [7:0] do8;
   logic       dv8, ff8, fe8, af8, ae8, ovf8, unf8;
   logic [3:0] cnt8;

   // DEPTH=16 instance signals
   logic [7:0] din16;
   logic       we16, rreq16;
   logic [7:0] do16;
   logic       dv16, ff16, fe16, af16, ae16, ovf16, unf16;
   logic [4:0] cnt16;

   // DEPTH=4 instance signals
   logic [7:0] din4;
   logic       we4, rreq4;
   logic [7:0] do4;
   logic       dv4, ff4, fe4, af4, ae4, ovf4, unf4;
   logic [2:0] cnt4;

   int checks = 0;
   int errors = 0;

   vec_t tbl[$];

   sync_fifo_param #(.WIDTH(8), .DEPTH(8)) u8 (
      .CLK(clk), .RSTN(rst_n), .DIN(din8), .WE(we8), .RREQ(rreq8), .FLUSH(flush8),
      .DO(do8), .DV(dv8), .FF(ff8), .FE(fe8), .AF(af8), .AE(ae8), .CNT(cnt8),
      .OVF(ovf8), .UNF(unf8)
   );

   sync_fifo_param #(.WIDTH(8), .DEPTH(16)) u16 (
      .CLK(clk), .RSTN(rst16_n), .DIN(din16), .WE(we16), .RREQ(rreq16), .FLUSH(1'b0),
      .DO(do16), .DV(dv16), .FF(ff16), .FE(fe16), .AF(af16), .AE(ae16), .CNT(cnt16),
      .OVF(ovf16), .UNF(unf16)
   );

   sync_fifo_param #(.WIDTH(8), .DEPTH(4)) u4 (
      .CLK(clk), .RSTN(rst_n), .DIN(din4), .WE(we4), .RREQ(rreq4), .FLUSH(1'b0),
      .DO(do4), .DV(dv4), .FF(ff4), .FE(fe4), .AF(af4), .AE(ae4), .CNT(cnt4),
      .OVF(ovf4), .UNF(unf4)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic rreq, input logic flush,
                               input logic [7:0] din, input logic [7:0] e_do,
                               input logic e_dv, input logic [3:0] e_cnt,
                               input logic e_ff, input logic e_fe, input logic e_af,
                               input logic e_ae, input logic e_ovf, input logic e_unf);
      vec_t v;
      v.we = we; v.rreq = rreq; v.flush = flush; v.din = din;
      v.e_do = e_do; v.e_dv = e_dv; v.e_cnt = e_cnt; v.e_ff = e_ff; v.e_fe = e_fe;
      v.e_af = e_af; v.e_ae = e_ae; v.e_ovf = e_ovf; v.e_unf = e_unf;
      return v;
   endfunction

   task automatic chk8(input string tag, input logic [7:0] e_do, input logic e_dv,
                       input logic [3:0] e_cnt, input logic e_ff, input logic e_fe,
                       input logic e_af, input logic e_ae, input logic e_ovf, input logic e_unf);
      chk({tag, ".do"},  64'(do8),  64'(e_do));
      chk({tag, ".dv"},  64'(dv8),  64'(e_dv));
      chk({tag, ".cnt"}, 64'(cnt8), 64'(e_cnt));
      chk({tag, ".ff"},  64'(ff8),  64'(e_ff));
      chk({tag, ".fe"},  64'(fe8),  64'(e_fe));
      chk({tag, ".af"},  64'(af8),  64'(e_af));
      chk({tag, ".ae"},  64'(ae8),  64'(e_ae));
      chk({tag, ".ovf"}, 64'(ovf8), 64'(e_ovf));
      chk({tag, ".unf"}, 64'(unf8), 64'(e_unf));
   endtask

   task automatic drive8(input logic we, input logic rreq, input logic flush, input logic [7:0] din);
      we8 = we; rreq8 = rreq; flush8 = flush; din8 = din;
      @(posedge clk);
      #1;
      we8 = 1'b0; rreq8 = 1'b0; flush8 = 1'b0; din8 = 8'h00;
   endtask

   initial begin
      logic [7:0] exp_data;
      int c;

      // ---- vector table for the DEPTH=8 instance (AF_LVL=6, AE_LVL=2) ----
      for (int k = 1; k <= 8; k++) begin
         tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'(k), 8'h00, 1'b0, 4'(k),
                          (k == 8), 1'b0, (k >= 6), (k <= 2), 1'b0, 1'b0));
      end
      // full: simultaneous read+write returns oldest, count stays 8
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 8'h55, 8'h01, 1'b1, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      // full: rejected write sets OVF, DO holds
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'hAA, 8'h01, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
      // drain: 02..08 then 55, AA never appears
      for (int k = 0; k < 8; k++) begin
         c = 7 - k;
         exp_data = (k < 7) ? 8'(k + 2) : 8'h55;
         tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, exp_data, 1'b1, 4'(c),
                          1'b0, (c == 0), (c >= 6), (c <= 2), 1'b1, 1'b0));
      end
      // empty: rejected read sets UNF, DO holds, DV low
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h55, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
      // empty: write+read -> no bypass, CNT=1
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 8'h33, 8'h55, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
      // flush clears sticky flags
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 8'h33, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));

      rst_n = 1'b0; rst16_n = 1'b0;
      din8 = 8'h00; we8 = 1'b0; rreq8 = 1'b0; flush8 = 1'b0;
      din16 = 8'h00; we16 = 1'b0; rreq16 = 1'b0;
      din4 = 8'h00; we4 = 1'b0; rreq4 = 1'b0;

      #2;
      chk8("reset", 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      #10;
      rst_n = 1'b1; rst16_n = 1'b1;

      // ---- table-driven run ----
      for (int i = 0; i < tbl.size(); i++) begin
         drive8(tbl[i].we, tbl[i].rreq, tbl[i].flush, tbl[i].din);
         chk8($sformatf("vec%0d", i), tbl[i].e_do, tbl[i].e_dv, tbl[i].e_cnt, tbl[i].e_ff,
              tbl[i].e_fe, tbl[i].e_af, tbl[i].e_ae, tbl[i].e_ovf, tbl[i].e_unf);
      end

      // ---- flush with pending requests at CNT=5 and OVF=1 ----
      for (int k = 0; k < 8; k++) drive8(1'b1, 1'b0, 1'b0, 8'(8'hA0 + k));
      drive8(1'b1, 1'b0, 1'b0, 8'hEE);
      for (int k = 0; k < 3; k++) begin
         drive8(1'b0, 1'b1, 1'b0, 8'h00);
         chk($sformatf("pre_flush_rd%0d", k), 64'(do8), 64'(8'hA0 + k));
      end
      chk8("pre_flush", 8'hA2, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive8(1'b1, 1'b1, 1'b1, 8'h77);
      chk8("flush", 8'hA2, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive8(1'b0, 1'b1, 1'b0, 8'h00);
      chk8("post_flush_rd", 8'hA2, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

      // ---- DEPTH=16: async reset mid-stream ----
      for (int k = 0; k < 5; k++) begin
         we16 = 1'b1; din16 = 8'(8'h10 + k);
         @(posedge clk); #1;
      end
      we16 = 1'b0; rreq16 = 1'b1;
      @(posedge clk); #1;
      rreq16 = 1'b0;
      chk("r16_pre.do",  64'(do16),  64'(8'h10));
      chk("r16_pre.dv",  64'(dv16),  64'(1'b1));
      chk("r16_pre.cnt", 64'(cnt16), 64'(5'd4));
      #3;
      rst16_n = 1'b0;
      #1;
      chk("r16_rst.cnt", 64'(cnt16), 64'(5'd0));
      chk("r16_rst.fe",  64'(fe16),  64'(1'b1));
      chk("r16_rst.ae",  64'(ae16),  64'(1'b1));
      chk("r16_rst.dv",  64'(dv16),  64'(1'b0));
      chk("r16_rst.do",  64'(do16),  64'(8'h00));
      chk("r16_rst.ff",  64'(ff16),  64'(1'b0));
      #2;
      rst16_n = 1'b1;
      rreq16 = 1'b1;
      @(posedge clk); #1;
      rreq16 = 1'b0;
      chk("r16_post.unf", 64'(unf16), 64'(1'b1));
      chk("r16_post.dv",  64'(dv16),  64'(1'b0));
      chk("r16_post.af",  64'(af16),  64'(1'b0));
      chk("r16_post.ovf", 64'(ovf16), 64'(1'b0));

      // ---- DEPTH=4: wrap-around at CNT=2 ----
      for (int k = 0; k < 2; k++) begin
         we4 = 1'b1; din4 = 8'(k);
         @(posedge clk); #1;
      end
      for (int k = 0; k < 10; k++) begin
         we4 = 1'b1; rreq4 = 1'b1; din4 = 8'(k + 2);
         @(posedge clk); #1;
         chk($sformatf("wrap%0d.do", k),  64'(do4),  64'(k));
         chk($sformatf("wrap%0d.dv", k),  64'(dv4),  64'(1'b1));
         chk($sformatf("wrap%0d.cnt", k), 64'(cnt4), 64'(3'd2));
         chk($sformatf("wrap%0d.flags", k), 64'({ff4, fe4, ovf4, unf4}), 64'(4'b0000));
      end
      we4 = 1'b0; rreq4 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
